spatial_encoder_param: RTL and testbench
========================================

SPATIAL_ENCODER_PARAM -- requirements
Module: spatial_encoder_param

Interface
REQ-001 SHALL provide parameter HV_DIM, default 2000, hypervector width in bits.
REQ-002 SHALL provide parameter CH_WIDTH, default 8, signed feature width per channel.
REQ-003 SHALL provide parameter NUM_MOD, default 3, range 1..4, number of modalities.
REQ-004 SHALL provide parameters MOD_CH0..MOD_CH3, defaults 32/77/105/0, channel count per modality (each >=2 if used); TOT_CH = sum of the used counts; MAX_CH = largest used count; AW = ceilLog2(MAX_CH).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports Clk_CI and Reset_RBI.
REQ-006 SHALL provide ports as follows, clock and reset first:
  Clk_CI  in  1  clock
  Reset_RBI  in  1  async active-low reset
  ValidIn_SI  in  1  input sample valid
  ReadyOut_SO  out  1  block accepts sample
  ChannelsInput_DI  in  CH_WIDTH*TOT_CH  packed features, modality 0 first
  SramAddr_DO  out  AW  channel index inside each modality
  SramReq_SO  out  NUM_MOD  per-modality fetch request
  SramValid_SI  in  NUM_MOD  per-modality fetch data valid
  IM_DI, ProjPos_DI, ProjNeg_DI  in  HV_DIM*NUM_MOD each  per-modality item/projection vectors
  ValidOut_SO  out  1  result valid
  ReadyIn_SI  in  1  downstream ready
  HypervectorOut_DO  out  HV_DIM*NUM_MOD  per-modality encoded vectors
  HypervectorFused_DO  out  HV_DIM  cross-modality result (REQ-022)

Function
REQ-007 SHALL use the FSM states IDLE, FETCH, ACCUM and DONE.
REQ-008 IDLE: ReadyOut_SO=1; on ValidIn_SI, SHALL latch all channels, clear the counter and all accumulators, and go to FETCH.
REQ-009 Modality m is active while counter < MOD_CH_m; SramReq_SO[m] SHALL be asserted in FETCH/ACCUM only while m is active.
REQ-010 FETCH/ACCUM: a step SHALL occur only in a cycle where SramValid_SI[m]=1 for every active m; otherwise hold all state (stall of any length).
REQ-011 Each step SHALL process one channel for every active modality; sel = ProjPos if feature >= 0, else ProjNeg; channel HV = IM XOR sel.
REQ-012 Each modality SHALL hold HV_DIM saturating counters of width ceilLog2(MOD_CH_m+1), incremented where the channel HV bit is 1.
REQ-013 On step 1 (channel index 1) the block SHALL latch tie = channel-0 HV XOR channel-1 HV per modality.
REQ-014 After the step at index MOD_CH_m-1, the output bit SHALL be 1 if count*2 > MOD_CH_m, 0 if count*2 < MOD_CH_m, and the tie bit on equality; the result is registered into HypervectorOut_DO[m].
REQ-015 After the step at index MAX_CH-1, the FSM SHALL go to DONE; ACCUM holds after the first step; total latency = MAX_CH steps plus stall cycles.
REQ-016 DONE: ValidOut_SO=1 and outputs stable until ReadyIn_SI; on ReadyIn_SI go to IDLE the next cycle.
REQ-017 ValidIn_SI outside IDLE SHALL be ignored; ReadyOut_SO=0 outside IDLE.
REQ-018 SramAddr_DO SHALL equal the counter; modality m's memory adds its own base offset externally.
REQ-019 An inactive modality SHALL neither update nor be stalled by its SramValid_SI bit.
REQ-020 Counter SHALL wrap to 0 on leaving ACCUM; it SHALL never exceed MAX_CH-1.

Reset
REQ-021 Reset_RBI low SHALL immediately force IDLE, counter=0, accumulators, tie registers and all data outputs to 0, ValidOut_SO=0, SramReq_SO=0, and ReadyOut_SO=1 after release, including mid-ACCUM.

Configuration
REQ-022 With macro SPATIAL_FUSION_MAJORITY_EN defined, HypervectorFused_DO SHALL be the bitwise majority of the NUM_MOD outputs (for even NUM_MOD, ties take the modality-0 bit), registered with the outputs; without it, HypervectorFused_DO SHALL be constant 0 and no fusion logic is built.

Verification
REQ-023 HV_DIM=8, NUM_MOD=1, MOD_CH0=3, IM=0xFF, ProjPos=0x0F, features {+1,+2,+3}, SramValid always 1 -> HypervectorOut=0xF0, ValidOut 3 steps after acceptance.
REQ-024 MOD_CH0=2, channel HVs 0xAA and 0x55 -> all counts equal 1 (tie) -> output = 0xAA^0x55 = 0xFF.
REQ-025 Defaults, SramValid[2] held low for 5 cycles at index 40 -> no counter advance and no accumulator change during the stall; ValidOut delayed exactly 5 cycles versus no stall.
REQ-026 Defaults, index 32..104 -> SramReq[0]=0 and SramValid[0]=0 does not stall; modality-0 output is frozen from index 32 onward.
REQ-027 Reset_RBI pulsed low at index 50 -> all outputs 0 and ReadyOut_SO=1 on release; a new sample then encodes correctly.
REQ-028 With SPATIAL_FUSION_MAJORITY_EN, per-modality outputs 0xF0/0xCC/0xAA (HV_DIM=8) -> HypervectorFused_DO=0xE8; without the macro -> 0x00.

Source files
------------

// File: rtl/spatial_encoder_param.sv
// spatial_encoder_param: multi-modality spatial HDC encoder (bind channels, bundle by majority).
// Optional feature macro SPATIAL_FUSION_MAJORITY_EN builds the cross-modality majority output.
module spatial_encoder_param #(
    parameter int HV_DIM   = 2000,
    parameter int CH_WIDTH = 8,
    parameter int NUM_MOD  = 3,
    parameter int MOD_CH0  = 32,
    parameter int MOD_CH1  = 77,
    parameter int MOD_CH2  = 105,
    parameter int MOD_CH3  = 0,
    localparam int MC0     = MOD_CH0,
    localparam int MC1     = (NUM_MOD > 1) ? MOD_CH1 : 0,
    localparam int MC2     = (NUM_MOD > 2) ? MOD_CH2 : 0,
    localparam int MC3     = (NUM_MOD > 3) ? MOD_CH3 : 0,
    localparam int TOT_CH  = MC0 + MC1 + MC2 + MC3,
    localparam int MAX01   = (MC0 > MC1) ? MC0 : MC1,
    localparam int MAX23   = (MC2 > MC3) ? MC2 : MC3,
    localparam int MAX_CH  = (MAX01 > MAX23) ? MAX01 : MAX23,
    localparam int AW      = $clog2(MAX_CH)
) (
    input  logic                        Clk_CI,
    input  logic                        Reset_RBI,
    input  logic                        ValidIn_SI,
    output logic                        ReadyOut_SO,
    input  logic [CH_WIDTH*TOT_CH-1:0]  ChannelsInput_DI,
    output logic [AW-1:0]               SramAddr_DO,
    output logic [NUM_MOD-1:0]          SramReq_SO,
    input  logic [NUM_MOD-1:0]          SramValid_SI,
    input  logic [HV_DIM*NUM_MOD-1:0]   IM_DI,
    input  logic [HV_DIM*NUM_MOD-1:0]   ProjPos_DI,
    input  logic [HV_DIM*NUM_MOD-1:0]   ProjNeg_DI,
    output logic                        ValidOut_SO,
    input  logic                        ReadyIn_SI,
    output logic [HV_DIM*NUM_MOD-1:0]   HypervectorOut_DO,
    output logic [HV_DIM-1:0]           HypervectorFused_DO
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ACCUM = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [AW-1:0] LAST = AW'(MAX_CH - 1);

    function automatic int mod_ch(input int i);
        return (i == 0) ? MC0 : (i == 1) ? MC1 : (i == 2) ? MC2 : MC3;
    endfunction

    function automatic int mod_off(input int i);
        return (i == 0) ? 0 : (i == 1) ? MC0 : (i == 2) ? MC0 + MC1 : MC0 + MC1 + MC2;
    endfunction

    logic [1:0]                   state_q, state_d;
    logic [AW-1:0]                cnt_q, cnt_d;
    logic [CH_WIDTH*TOT_CH-1:0]   feat_q, feat_d;
    logic [NUM_MOD-1:0]           act;
    logic                         busy, accept, step, last;

    assign busy        = (state_q == FETCH) || (state_q == ACCUM);
    assign accept      = (state_q == IDLE) && ValidIn_SI;
    assign step        = busy && (&(SramValid_SI | ~act));
    assign last        = cnt_q == LAST;
    assign ReadyOut_SO = state_q == IDLE;
    assign ValidOut_SO = state_q == DONE;
    assign SramAddr_DO = cnt_q;
    assign SramReq_SO  = busy ? act : '0;

    // Next state: accept a sample, advance one channel per fully-valid step, hand off in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        feat_d  = feat_q;
        if (accept) begin
            state_d = FETCH;
            cnt_d   = '0;
            feat_d  = ChannelsInput_DI;
        end else if (step) begin
            state_d = last ? DONE : ACCUM;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
        end else if (state_q == DONE && ReadyIn_SI) begin
            state_d = IDLE;
        end
    end

    // FSM, channel counter and latched sample registers
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            feat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            feat_q  <= feat_d;
        end
    end

`ifdef SPATIAL_FUSION_MAJORITY_EN
    logic [HV_DIM*NUM_MOD-1:0] hv_nxt;
`endif

    for (genvar m = 0; m < NUM_MOD; m++) begin : g_mod
        localparam int N  = mod_ch(m);
        localparam int CW = $clog2(N + 1);
        localparam logic [CW-1:0] SAT = '1;

        logic [CW-1:0]       acc_q [HV_DIM];
        logic [CW-1:0]       acc_d [HV_DIM];
        logic [HV_DIM-1:0]   tie_q, tie_d, out_q, out_d, chv;
        logic [CH_WIDTH-1:0] feat;
        logic                upd, fin;

        assign act[m] = int'(cnt_q) < N;
        // Inactive modalities point at their first channel so the select never leaves the sample
        assign feat   = feat_q[(mod_off(m) + (act[m] ? int'(cnt_q) : 0)) * CH_WIDTH +: CH_WIDTH];
        assign chv    = IM_DI[m*HV_DIM +: HV_DIM] ^ (($signed(feat) < 0) ?
                        ProjNeg_DI[m*HV_DIM +: HV_DIM] : ProjPos_DI[m*HV_DIM +: HV_DIM]);
        assign upd    = step && act[m];
        assign fin    = upd && (int'(cnt_q) == N - 1);
        assign HypervectorOut_DO[m*HV_DIM +: HV_DIM] = out_q;

        // Per-bit count, tie capture (acc bit 0 still holds channel 0 at index 1) and majority
        always_comb begin
            for (int b = 0; b < HV_DIM; b++) begin
                acc_d[b] = (acc_q[b] == SAT) ? acc_q[b] : acc_q[b] + CW'(chv[b]);
                tie_d[b] = (int'(cnt_q) == 1) ? acc_q[b][0] ^ chv[b] : tie_q[b];
                out_d[b] = (2 * int'(acc_d[b]) > N) ? 1'b1 :
                           (2 * int'(acc_d[b]) < N) ? 1'b0 : tie_d[b];
            end
        end

        // Accumulators and tie bits clear on accept; result registers on the final channel
        always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
            if (!Reset_RBI) begin
                for (int b = 0; b < HV_DIM; b++) acc_q[b] <= '0;
                tie_q <= '0;
                out_q <= '0;
            end else if (accept) begin
                for (int b = 0; b < HV_DIM; b++) acc_q[b] <= '0;
                tie_q <= '0;
            end else if (upd) begin
                for (int b = 0; b < HV_DIM; b++) acc_q[b] <= acc_d[b];
                tie_q <= tie_d;
                if (fin) out_q <= out_d;
            end
        end

`ifdef SPATIAL_FUSION_MAJORITY_EN
        assign hv_nxt[m*HV_DIM +: HV_DIM] = fin ? out_d : out_q;
`endif
    end

`ifdef SPATIAL_FUSION_MAJORITY_EN
    logic [HV_DIM-1:0] fus_q, fus_d;

    function automatic logic maj(input logic [HV_DIM*NUM_MOD-1:0] v, input int b);
        int n;
        n = 0;
        for (int m = 0; m < NUM_MOD; m++) n += int'(v[m*HV_DIM + b]);
        return (2 * n > NUM_MOD) ? 1'b1 : (2 * n < NUM_MOD) ? 1'b0 : v[b];
    endfunction

    // Bitwise vote over the next per-modality outputs; even ties follow modality 0
    always_comb begin
        for (int b = 0; b < HV_DIM; b++) fus_d[b] = maj(hv_nxt, b);
    end

    // Fused result registers alongside the per-modality outputs
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) fus_q <= '0;
        else            fus_q <= fus_d;
    end

    assign HypervectorFused_DO = fus_q;
`else
    assign HypervectorFused_DO = '0;
`endif

endmodule

// File: tb/tb_spatial_encoder_param.sv
// tb_spatial_encoder_param: randomized bench with a per-channel bundling reference model
module tb_spatial_encoder_param;

    localparam int HV   = 8;
    localparam int CHW  = 8;
    localparam int NM   = 3;
    localparam int TOT  = 11;
    localparam int MAXC = 6;
    localparam int MC  [NM] = '{3, 2, 6};
    localparam int OFF [NM] = '{0, 3, 5};

    logic              clk = 0;
    logic              rst_n = 0;
    logic              vin = 0;
    logic              rdy_in = 0;
    logic              rdy_out, vout;
    logic [CHW*TOT-1:0] ch_in = '0;
    logic [2:0]        addr;
    logic [NM-1:0]     req;
    logic [NM-1:0]     sv = '0;
    logic [HV*NM-1:0]  im = '0, pp = '0, pn = '0, hv_out;
    logic [HV-1:0]     fused;

    int n_chk = 0;
    int n_bad = 0;
    logic [HV-1:0]         exp_out [NM];
    logic [HV-1:0]         chv [NM][MAXC];
    logic signed [CHW-1:0] feats [TOT];

    always #5 clk = ~clk;

    spatial_encoder_param #(
        .HV_DIM(HV), .CH_WIDTH(CHW), .NUM_MOD(NM),
        .MOD_CH0(3), .MOD_CH1(2), .MOD_CH2(6), .MOD_CH3(0)
    ) dut (
        .Clk_CI(clk),
        .Reset_RBI(rst_n),
        .ValidIn_SI(vin),
        .ReadyOut_SO(rdy_out),
        .ChannelsInput_DI(ch_in),
        .SramAddr_DO(addr),
        .SramReq_SO(req),
        .SramValid_SI(sv),
        .IM_DI(im),
        .ProjPos_DI(pp),
        .ProjNeg_DI(pn),
        .ValidOut_SO(vout),
        .ReadyIn_SI(rdy_in),
        .HypervectorOut_DO(hv_out),
        .HypervectorFused_DO(fused)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Majority of all channel vectors of modality m; ties take channel0 ^ channel1
    function automatic logic [HV-1:0] bundle(input int m);
        logic [HV-1:0] r;
        int ones;
        for (int b = 0; b < HV; b++) begin
            ones = 0;
            for (int k = 0; k < MC[m]; k++) ones += int'(chv[m][k][b]);
            r[b] = (2 * ones > MC[m]) ? 1'b1 : (2 * ones < MC[m]) ? 1'b0 : chv[m][0][b] ^ chv[m][1][b];
        end
        return r;
    endfunction

    function automatic logic [HV-1:0] fuse_exp();
        logic [HV-1:0] r;
        int ones;
        r = '0;
`ifdef SPATIAL_FUSION_MAJORITY_EN
        for (int b = 0; b < HV; b++) begin
            ones = 0;
            for (int m = 0; m < NM; m++) ones += int'(exp_out[m][b]);
            r[b] = (2 * ones > NM) ? 1'b1 : (2 * ones < NM) ? 1'b0 : exp_out[0][b];
        end
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 1: directed vectors with no stalls; abort_at >= 0 pulses reset at that channel index
    task automatic run(input int mode, input int abort_at);
        int k, cyc;
        logic [NM-1:0] act;
        logic step;
        logic [HV-1:0] iv, pv, nv;
        for (int i = 0; i < TOT; i++) begin
            feats[i] = (mode == 1 && i < 3) ? CHW'(i + 1) :
                       ($urandom_range(0, 7) == 0) ? '0 : CHW'($urandom);
            ch_in[i*CHW +: CHW] = feats[i];
        end
        chk("idle_rdy", rdy_out, 1);
        chk("idle_vout", vout, 0);
        vin = 1;
        tick();
        vin = 0;
        k = 0;
        cyc = 0;
        while (k < MAXC && cyc < 200) begin
            for (int m = 0; m < NM; m++) act[m] = k < MC[m];
            chk("addr", addr, k);
            chk("req", req, act);
            chk("busy_rdy", rdy_out, 0);
            chk("busy_vout", vout, 0);
            for (int m = 0; m < NM; m++)
                if (k >= MC[m]) chk("frozen", hv_out[m*HV +: HV], exp_out[m]);
            if (k == abort_at) begin
                #1 rst_n = 0;
                #1;
                chk("rst_rdy", rdy_out, 1);
                chk("rst_vout", vout, 0);
                chk("rst_req", req, 0);
                chk("rst_addr", addr, 0);
                chk("rst_hv", hv_out, 0);
                chk("rst_fused", fused, 0);
                for (int m = 0; m < NM; m++) exp_out[m] = '0;
                rst_n = 1;
                return;
            end
            for (int m = 0; m < NM; m++) sv[m] = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            vin = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (vin)
                for (int i = 0; i < TOT; i++) ch_in[i*CHW +: CHW] = CHW'($urandom);
            step = &(sv | ~act);
            for (int m = 0; m < NM; m++) begin
                iv = HV'($urandom);
                pv = HV'($urandom);
                nv = HV'($urandom);
                if (mode == 1 && m == 0) begin
                    iv = 8'hFF;
                    pv = 8'h0F;
                end
                if (mode == 1 && m == 1) begin
                    iv = (k == 0) ? 8'hAA : 8'h55;
                    pv = '0;
                    nv = '0;
                end
                im[m*HV +: HV] = iv;
                pp[m*HV +: HV] = pv;
                pn[m*HV +: HV] = nv;
                if (step && act[m]) chv[m][k] = iv ^ ((feats[OFF[m] + k] >= 0) ? pv : nv);
            end
            tick();
            if (step) begin
                for (int m = 0; m < NM; m++)
                    if (k == MC[m] - 1) exp_out[m] = bundle(m);
                k++;
            end
            cyc++;
        end
        vin = 0;
        sv = '0;
        chk("timeout", cyc < 200, 1);
        chk("done_vout", vout, 1);
        chk("done_rdy", rdy_out, 0);
        chk("done_req", req, 0);
        for (int m = 0; m < NM; m++) chk("hv", hv_out[m*HV +: HV], exp_out[m]);
        chk("fused", fused, fuse_exp());
        if (mode == 1) begin
            chk("pos_bundle", hv_out[0 +: HV], 8'hF0);
            chk("tie_bundle", hv_out[HV +: HV], 8'hFF);
        end
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk("hold_vout", vout, 1);
            chk("hold_hv", hv_out, {exp_out[2], exp_out[1], exp_out[0]});
        end
        rdy_in = 1;
        tick();
        rdy_in = 0;
        chk("ret_rdy", rdy_out, 1);
        chk("ret_vout", vout, 0);
    endtask

    initial begin
        for (int m = 0; m < NM; m++) exp_out[m] = '0;
        repeat (2) @(negedge clk);
        chk("reset_rdy", rdy_out, 1);
        chk("reset_vout", vout, 0);
        chk("reset_req", req, 0);
        chk("reset_addr", addr, 0);
        chk("reset_hv", hv_out, 0);
        chk("reset_fused", fused, 0);
        rst_n = 1;
        @(negedge clk);
        run(1, -1);
        run(0, 3);
        run(1, -1);
        run(0, 1);
        repeat (40) run(0, -1);
        run(1, -1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
